// File: rtl/regfile_sb.sv
// Purpose: 2R/2W integer register file with same-cycle write bypass and per-register busy scoreboard.
// Latency: reads, busy1/busy2 and issue_rdy are combinational; writes and busy set/clear land at the rising edge.
// Backpressure: issue_rdy drops while issue_rd is effectively busy; a refused issue is not held and must be re-presented.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   a1/a2 -> rd1/rd2      read addresses and read data
//   busy1/busy2           effective busy of a1/a2
//   we0/a3_0/wd0          write port 0 (ALU writeback)
//   we1/a3_1/wd1          write port 1 (load return, wins on address collision)
//   issue_v/issue_rd      request to mark issue_rd busy; issue_rdy = accepted
//   busy_cnt              registered count of busy registers
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(NREG),
    localparam int CW      = $clog2(NREG + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we0,
    input  logic [AW-1:0]   a3_0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   a3_1,
    input  logic [XLEN-1:0] wd1,
    input  logic            issue_v,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_rdy,
    output logic [CW-1:0]   busy_cnt
);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy;

    // Writes that actually take effect: reset discards them, and register 0
    // swallows them when it is hardwired to zero.
    logic wr0, wr1;
    assign wr0 = rst_n && we0 && !(ZERO_REG && (a3_0 == '0));
    assign wr1 = rst_n && we1 && !(ZERO_REG && (a3_1 == '0));

    // clr: registers written this cycle; eb: effective busy (a retiring write
    // already frees its register in the same cycle).
    logic [NREG-1:0] clr, eb;
    always_comb begin
        clr = '0;
        for (int r = 0; r < NREG; r++) begin
            clr[r] = (wr0 && (a3_0 == AW'(r))) || (wr1 && (a3_1 == AW'(r)));
        end
        eb = busy & ~clr;
        if (ZERO_REG) eb[0] = 1'b0;
    end

    assign busy1     = eb[a1];
    assign busy2     = eb[a2];
    assign issue_rdy = issue_v && rst_n && !eb[issue_rd];

    // Issue to hardwired r0 is accepted but marks nothing.
    logic            set_v;
    logic [NREG-1:0] set_mask;
    assign set_v    = issue_rdy && !(ZERO_REG && (issue_rd == '0));
    assign set_mask = set_v ? (NREG'(1) << issue_rd) : '0;

    // Incremental count: a busy register freed and not re-set decrements once
    // (a dual-port write to the same register counts once); a set on a
    // register not currently busy increments.
    logic dec0, dec1, inc;
    assign dec0 = wr0 && busy[a3_0] && !(set_v && (issue_rd == a3_0));
    assign dec1 = wr1 && busy[a3_1] && !(set_v && (issue_rd == a3_1))
                  && !(wr0 && (a3_0 == a3_1));
    assign inc  = set_v && !busy[issue_rd];

    // Read mux: hardwired zero, then port 1 bypass, then port 0, then array.
    always_comb begin
        rd1 = mem[a1];
        if (ZERO_REG && (a1 == '0))                       rd1 = '0;
        else if (BYPASS && rst_n && we1 && (a3_1 == a1))  rd1 = wd1;
        else if (BYPASS && rst_n && we0 && (a3_0 == a1))  rd1 = wd0;
    end

    always_comb begin
        rd2 = mem[a2];
        if (ZERO_REG && (a2 == '0))                       rd2 = '0;
        else if (BYPASS && rst_n && we1 && (a3_1 == a2))  rd2 = wd1;
        else if (BYPASS && rst_n && we0 && (a3_0 == a2))  rd2 = wd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                mem[r] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            // Port 1 is assigned last so it wins an address collision.
            if (wr0) mem[a3_0] <= wd0;
            if (wr1) mem[a3_1] <= wd1;
            busy     <= (busy & ~clr) | set_mask;
            busy_cnt <= busy_cnt + CW'(inc) - CW'(dec0) - CW'(dec1);
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  a1, a2, a3_0, a3_1, issue_rd;
    logic [31:0] wd0, wd1;
    logic        we0, we1, issue_v;
    logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
    logic        busy1, busy2, issue_rdy;
    logic        nb_busy1, nb_busy2, nb_issue_rdy;
    logic [5:0]  busy_cnt, nb_busy_cnt;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2),
        .we0(we0), .a3_0(a3_0), .wd0(wd0), .we1(we1), .a3_1(a3_1), .wd1(wd1),
        .issue_v(issue_v), .issue_rd(issue_rd), .issue_rdy(issue_rdy),
        .busy_cnt(busy_cnt)
    );

    regfile_sb #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .rd1(nb_rd1), .rd2(nb_rd2),
        .busy1(nb_busy1), .busy2(nb_busy2),
        .we0(we0), .a3_0(a3_0), .wd0(wd0), .we1(we1), .a3_1(a3_1), .wd1(wd1),
        .issue_v(issue_v), .issue_rd(issue_rd), .issue_rdy(nb_issue_rdy),
        .busy_cnt(nb_busy_cnt)
    );

    // Reference model: plain array of values and a set of busy registers.
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    bit          ready = 1'b0;
    int          total = 0;
    int          passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] e_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && rst_n && we1 && a3_1 == a) return wd1;
        if (byp && rst_n && we0 && a3_0 == a) return wd0;
        return m_mem[a];
    endfunction

    function automatic bit e_busy(input logic [4:0] a);
        bit written;
        written = rst_n && ((we0 && a3_0 == a) || (we1 && a3_1 == a));
        return (a != 0) && m_busy[a] && !written;
    endfunction

    function automatic bit e_rdy();
        return issue_v && rst_n && !e_busy(issue_rd);
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    task automatic model_edge();
        bit rdy;
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[r]  = 32'h0;
                m_busy[r] = 1'b0;
            end
            ready = 1'b1;
        end else begin
            rdy = e_rdy();
            if (we0 && a3_0 != 0) m_mem[a3_0] = wd0;
            if (we1 && a3_1 != 0) m_mem[a3_1] = wd1;
            if (we0) m_busy[a3_0] = 1'b0;
            if (we1) m_busy[a3_1] = 1'b0;
            if (rdy && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
    endtask

    // Settle combinational outputs and compare everything against the model.
    task automatic settle();
        #1;
        if (ready) begin
            chk("rd1", rd1, e_rd(a1, 1'b1));
            chk("rd2", rd2, e_rd(a2, 1'b1));
            chk("rd1_nobyp", nb_rd1, e_rd(a1, 1'b0));
            chk("rd2_nobyp", nb_rd2, e_rd(a2, 1'b0));
            chk("busy1", 32'(busy1), 32'(e_busy(a1)));
            chk("busy2", 32'(busy2), 32'(e_busy(a2)));
            chk("issue_rdy", 32'(issue_rdy), 32'(e_rdy()));
            chk("busy_cnt", 32'(busy_cnt), 32'(m_cnt()));
            chk("busy_cnt_nobyp", 32'(nb_busy_cnt), 32'(m_cnt()));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic idle();
        rst_n = 1'b1; we0 = 1'b0; we1 = 1'b0; issue_v = 1'b0;
        a3_0 = '0; a3_1 = '0; wd0 = '0; wd1 = '0; issue_rd = '0;
    endtask

    initial begin
        idle();
        a1 = 5'd0; a2 = 5'd0;

        // Power-up reset, then check reset-exit state.
        rst_n = 1'b0;
        cycle(); cycle();
        idle();
        issue_v = 1'b1; issue_rd = 5'd9; a1 = 5'd9;
        settle();
        chk("exit_rd1", rd1, 32'h0);
        chk("exit_rdy", 32'(issue_rdy), 32'd1);
        chk("exit_cnt", 32'(busy_cnt), 32'd0);
        issue_v = 1'b0;
        tick();

        // Reset clears stored data.
        we0 = 1'b1; a3_0 = 5'd5; wd0 = 32'hDEADBEEF; a1 = 5'd5;
        cycle();
        idle();
        rst_n = 1'b0;
        cycle();
        idle();
        settle();
        chk("reset_r5", rd1, 32'h0);
        chk("reset_cnt", 32'(busy_cnt), 32'd0);
        tick();

        // Collision with bypass: port 1 wins, and is what gets stored.
        we0 = 1'b1; a3_0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; a3_1 = 5'd7; wd1 = 32'h22; a1 = 5'd7; a2 = 5'd7;
        settle();
        chk("collide_byp", rd1, 32'h22);
        chk("collide_nobyp_old", nb_rd1, 32'h0);
        tick();
        idle();
        settle();
        chk("collide_stored", rd1, 32'h22);
        chk("collide_stored_nobyp", nb_rd1, 32'h22);
        tick();

        // Register 0 ignores writes and issues.
        we0 = 1'b1; a3_0 = 5'd0; wd0 = 32'hFFFF_FFFF; issue_v = 1'b1; issue_rd = 5'd0;
        a1 = 5'd0;
        settle();
        chk("r0_rd", rd1, 32'h0);
        chk("r0_busy", 32'(busy1), 32'd0);
        chk("r0_rdy", 32'(issue_rdy), 32'd1);
        tick();
        idle();
        settle();
        chk("r0_cnt", 32'(busy_cnt), 32'd0);
        tick();

        // Scoreboard: issue, refuse WAW, same-cycle retire+reissue.
        issue_v = 1'b1; issue_rd = 5'd3; a1 = 5'd3;
        cycle();
        settle();
        chk("sb_busy", 32'(busy1), 32'd1);
        chk("sb_cnt", 32'(busy_cnt), 32'd1);
        chk("sb_refuse", 32'(issue_rdy), 32'd0);
        tick();
        we1 = 1'b1; a3_1 = 5'd3; wd1 = 32'h55;
        settle();
        chk("sb_reissue_rdy", 32'(issue_rdy), 32'd1);
        chk("sb_reissue_busy", 32'(busy1), 32'd0);
        tick();
        idle();
        settle();
        chk("sb_rebusy", 32'(busy1), 32'd1);
        chk("sb_recnt", 32'(busy_cnt), 32'd1);
        tick();

        // Count stress from a clean state.
        rst_n = 1'b0;
        cycle();
        idle();
        for (int r = 1; r < 32; r++) begin
            issue_v = 1'b1; issue_rd = 5'(r); a1 = 5'(r); a2 = 5'(r - 1);
            cycle();
        end
        issue_v = 1'b1; issue_rd = 5'd1;
        settle();
        chk("stress_full", 32'(busy_cnt), 32'd31);
        chk("stress_refuse", 32'(issue_rdy), 32'd0);
        tick();
        idle();
        for (int k = 0; k < 16; k++) begin
            we0 = 1'b1; a3_0 = 5'(2 * k + 1); wd0 = $urandom;
            we1 = (k < 15); a3_1 = 5'(2 * k + 2); wd1 = $urandom;
            a1 = a3_0; a2 = a3_1;
            cycle();
        end
        idle();
        settle();
        chk("stress_empty", 32'(busy_cnt), 32'd0);
        tick();

        // Reset mid-operation with a write to a busy register.
        issue_v = 1'b1; issue_rd = 5'd4;
        cycle();
        idle();
        rst_n = 1'b0; we0 = 1'b1; a3_0 = 5'd4; wd0 = 32'h99; a1 = 5'd4;
        cycle();
        idle();
        settle();
        chk("midrst_rd", rd1, 32'h0);
        chk("midrst_busy", 32'(busy1), 32'd0);
        chk("midrst_cnt", 32'(busy_cnt), 32'd0);
        tick();

        // Random traffic on a narrow address range to force collisions.
        for (int i = 0; i < 400; i++) begin
            rst_n    = ($urandom_range(0, 59) != 0);
            we0      = $urandom_range(0, 2) == 0;
            we1      = $urandom_range(0, 2) == 0;
            issue_v  = $urandom_range(0, 1) == 1;
            a3_0     = 5'($urandom_range(0, 7));
            a3_1     = 5'($urandom_range(0, 7));
            issue_rd = 5'($urandom_range(0, 7));
            a1       = 5'($urandom_range(0, 7));
            a2       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : a3_1;
            wd0      = $urandom;
            wd1      = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
